// File: rtl/fpu_ss_req_buffer_pkg.sv
// Shared types and constants for the FPU-SS request buffer.
package fpu_ss_req_buffer_pkg;

    localparam int unsigned ID_WIDTH  = 4;
    localparam int unsigned BUF_DEPTH = 4;

    // One offloaded instruction with its operands and predecode flags.
    typedef struct packed {
        logic [31:0]         instr;
        logic [31:0]         rs1;
        logic [31:0]         rs2;
        logic [ID_WIDTH-1:0] id;
        logic                writeback;
        logic                is_mem_op;
    } req_entry_t;

endpackage

// File: rtl/fpu_ss_req_buffer_if.sv
// Request-in / issue-out handshake bundle around the request buffer.
interface fpu_ss_req_buffer_if;
    import fpu_ss_req_buffer_pkg::*;

    logic       in_valid;
    logic       in_ready;
    req_entry_t in_entry;
    logic       out_valid;
    logic       out_ready;
    req_entry_t out_entry;

    // Buffer side: accepts pushes, presents the head.
    modport slave (
        input  in_valid, in_entry, out_ready,
        output in_ready, out_valid, out_entry
    );

    // Environment side: producer of pushes and consumer of the head.
    modport master (
        output in_valid, in_entry, out_ready,
        input  in_ready, out_valid, out_entry
    );
endinterface

// File: rtl/fpu_ss_req_buffer.sv
// Elastic in-order buffer between the X-interface request channel and the
// FPU-SS decoder. Holds a load/store at the head while the memory path is busy
// and tracks how many buffered instructions still owe an integer writeback.
module fpu_ss_req_buffer
    import fpu_ss_req_buffer_pkg::*;
#(
    parameter int unsigned DEPTH = BUF_DEPTH
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       flush_i,
    input  logic                       mem_busy_i,
    fpu_ss_req_buffer_if.slave         bus,
    output logic [$clog2(DEPTH):0]     usage_o,
    output logic [$clog2(DEPTH):0]     wb_pending_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    // Pointers carry an extra wrap bit so full and empty are distinguishable.
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic          ready_en;
    req_entry_t    mem [DEPTH];
    req_entry_t    head;
    logic          full, empty, push, pop, wb_inc, wb_dec;

    assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
    assign empty = (wr_ptr == rd_ptr);
    assign head  = mem[rd_ptr[AW-1:0]];

    // ready_en keeps in_ready low during reset and only depends on registered
    // state plus flush, so the consumer's ready never loops back to the producer.
    assign bus.in_ready  = ready_en & ~full & ~flush_i;
    assign bus.out_entry = empty ? '0 : head;
    // A load/store head blocks the whole queue while memory is busy: no reordering.
    assign bus.out_valid = ~empty & ~(head.is_mem_op & mem_busy_i);

    assign push   = bus.in_valid & bus.in_ready;
    assign pop    = bus.out_valid & bus.out_ready;
    assign wb_inc = push & bus.in_entry.writeback;
    assign wb_dec = pop & head.writeback;

    // Reset release: allow pushes from the first cycle after rst_ni deasserts.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) ready_en <= 1'b0;
        else         ready_en <= 1'b1;
    end

    // Entry storage: written on push only, never reset or cleared.
    always_ff @(posedge clk_i) begin
        if (push) mem[wr_ptr[AW-1:0]] <= bus.in_entry;
    end

    // Pointer update; flush discards everything, including a same-cycle pop.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Occupancy counter; full/empty gating keeps it within 0..DEPTH.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) usage_o <= '0;
        else if (flush_i) usage_o <= '0;
        else begin
            case ({push, pop})
                2'b10:   usage_o <= usage_o + 1'b1;
                2'b01:   usage_o <= usage_o - 1'b1;
                default: usage_o <= usage_o;
            endcase
        end
    end

    // Count of buffered entries that will produce an integer writeback.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) wb_pending_o <= '0;
        else if (flush_i) wb_pending_o <= '0;
        else begin
            case ({wb_inc, wb_dec})
                2'b10:   wb_pending_o <= wb_pending_o + 1'b1;
                2'b01:   wb_pending_o <= wb_pending_o - 1'b1;
                default: wb_pending_o <= wb_pending_o;
            endcase
        end
    end

    a_no_push_full: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(push && full));
    a_no_pop_empty: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(pop && empty));
    a_cnt_bounds: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (wb_pending_o <= usage_o) && (usage_o <= PW'(DEPTH)));

endmodule

// File: tb/tb_fpu_ss_req_buffer.sv
// Directed bench for the FPU-SS request buffer (DEPTH=4).
module tb_fpu_ss_req_buffer;
    import fpu_ss_req_buffer_pkg::*;

    logic       clk_i = 1'b0;
    logic       rst_ni = 1'b0;
    logic       flush_i = 1'b0;
    logic       mem_busy_i = 1'b0;
    logic [2:0] usage_o, wb_pending_o;
    int         checks = 0;
    int         failures = 0;

    fpu_ss_req_buffer_if bus ();

    fpu_ss_req_buffer #(.DEPTH(4)) dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .flush_i      (flush_i),
        .mem_busy_i   (mem_busy_i),
        .bus          (bus),
        .usage_o      (usage_o),
        .wb_pending_o (wb_pending_o)
    );

    always #5 clk_i = ~clk_i;

    // Inputs change 2 time units after the rising edge; checks happen 1 unit later.
    task automatic tick();
        @(posedge clk_i);
        #2;
    endtask

    function automatic req_entry_t mk(input logic [31:0] instr, input int id,
                                      input logic wb, input logic mo);
        req_entry_t e;
        e.instr     = instr;
        e.rs1       = 32'h1000_0000 + id;
        e.rs2       = 32'h2000_0000 + id;
        e.id        = ID_WIDTH'(id);
        e.writeback = wb;
        e.is_mem_op = mo;
        return e;
    endfunction

    task automatic test_reset();
        bus.in_valid = 1'b0; bus.out_ready = 1'b0; bus.in_entry = '0;
        rst_ni = 1'b0;
        repeat (2) @(posedge clk_i);
        #3;
        checks++; if (bus.in_ready !== 1'b0) begin failures++; $display("FAIL reset_in_ready got %b want 0", bus.in_ready); end
        checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got %b want 0", bus.out_valid); end
        checks++; if (usage_o !== 3'd0 || wb_pending_o !== 3'd0) begin failures++; $display("FAIL reset_counters got %0d/%0d want 0/0", usage_o, wb_pending_o); end
        checks++; if (bus.out_entry !== '0) begin failures++; $display("FAIL reset_out_entry got %h want 0", bus.out_entry); end
        rst_ni = 1'b1;
        #1;
        checks++; if (bus.in_ready !== 1'b0) begin failures++; $display("FAIL release_in_ready_early got %b want 0", bus.in_ready); end
        tick(); #1;
        checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL release_in_ready got %b want 1", bus.in_ready); end
    endtask

    task automatic test_fill();
        bus.out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            bus.in_valid = 1'b1; bus.in_entry = mk(32'h00A50553, i, 1'b0, 1'b0);
            #1;
            checks++; if (bus.in_ready !== (i < 4)) begin failures++; $display("FAIL fill_in_ready[%0d] got %b want %b", i, bus.in_ready, (i < 4)); end
            tick();
        end
        bus.in_valid = 1'b0;
        #1;
        checks++; if (usage_o !== 3'd4) begin failures++; $display("FAIL fill_usage got %0d want 4", usage_o); end
        // Full with a pop in the same cycle: the push is still refused.
        bus.in_valid = 1'b1; bus.in_entry = mk(32'h00A50553, 7, 1'b0, 1'b0); bus.out_ready = 1'b1;
        #1;
        checks++; if (bus.in_ready !== 1'b0) begin failures++; $display("FAIL full_pop_in_ready got %b want 0", bus.in_ready); end
        tick();
        bus.in_valid = 1'b0;
        #1;
        checks++; if (usage_o !== 3'd3) begin failures++; $display("FAIL full_pop_usage got %0d want 3", usage_o); end
        for (int i = 1; i < 4; i++) begin
            checks++; if (bus.out_valid !== 1'b1 || bus.out_entry.id !== ID_WIDTH'(i)) begin failures++; $display("FAIL drain_id got v=%b id=%0d want v=1 id=%0d", bus.out_valid, bus.out_entry.id, i); end
            tick(); #1;
        end
        bus.out_ready = 1'b0;
        checks++; if (usage_o !== 3'd0 || bus.out_valid !== 1'b0) begin failures++; $display("FAIL drain_empty got usage=%0d v=%b want 0/0", usage_o, bus.out_valid); end
    endtask

    task automatic test_latency();
        req_entry_t e;
        e = '0;
        e.instr = 32'h00A50553; e.rs1 = 32'h3F80_0000; e.rs2 = 32'h4000_0000; e.id = 4'd5;
        bus.in_valid = 1'b1; bus.in_entry = e; bus.out_ready = 1'b0;
        #1;
        checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL fallthrough got v=%b want 0", bus.out_valid); end
        tick();
        bus.in_valid = 1'b0;
        #1;
        checks++; if (bus.out_valid !== 1'b1 || bus.out_entry !== e) begin failures++; $display("FAIL latency_entry got v=%b %h want v=1 %h", bus.out_valid, bus.out_entry, e); end
        checks++; if (usage_o !== 3'd1) begin failures++; $display("FAIL latency_usage got %0d want 1", usage_o); end
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        #1;
        checks++; if (usage_o !== 3'd0 || bus.out_valid !== 1'b0 || bus.out_entry !== '0) begin failures++; $display("FAIL latency_pop got usage=%0d v=%b e=%h want 0/0/0", usage_o, bus.out_valid, bus.out_entry); end
    endtask

    task automatic test_wrap();
        int exp_id = 0;
        bus.out_ready = 1'b1;
        for (int c = 0; c < 13; c++) begin
            bus.in_valid = (c < 12); bus.in_entry = mk(32'h00A50553, c, 1'b0, 1'b0);
            #1;
            if (bus.out_valid) begin
                checks++; if (bus.out_entry.id !== ID_WIDTH'(exp_id)) begin failures++; $display("FAIL wrap_order got %0d want %0d", bus.out_entry.id, exp_id); end
                exp_id++;
            end
            checks++; if (usage_o > 3'd1) begin failures++; $display("FAIL wrap_usage got %0d want <=1", usage_o); end
            tick();
        end
        bus.in_valid = 1'b0; bus.out_ready = 1'b0;
        #1;
        checks++; if (exp_id != 12 || usage_o !== 3'd0) begin failures++; $display("FAIL wrap_count got %0d popped usage=%0d want 12/0", exp_id, usage_o); end
    endtask

    task automatic test_mem_gating();
        bus.out_ready = 1'b1; mem_busy_i = 1'b1;
        bus.in_valid = 1'b1; bus.in_entry = mk(32'h00052507, 1, 1'b0, 1'b1);
        tick();
        bus.in_entry = mk(32'h00A50553, 2, 1'b0, 1'b0);
        tick();
        bus.in_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            checks++; if (bus.out_valid !== 1'b0 || bus.out_entry.id !== 4'd1) begin failures++; $display("FAIL gate_busy[%0d] got v=%b id=%0d want v=0 id=1", k, bus.out_valid, bus.out_entry.id); end
            tick();
        end
        mem_busy_i = 1'b0;
        #1;
        checks++; if (bus.out_valid !== 1'b1 || bus.out_entry.id !== 4'd1) begin failures++; $display("FAIL gate_release got v=%b id=%0d want v=1 id=1", bus.out_valid, bus.out_entry.id); end
        tick(); #1;
        checks++; if (bus.out_valid !== 1'b1 || bus.out_entry.id !== 4'd2) begin failures++; $display("FAIL gate_next got v=%b id=%0d want v=1 id=2", bus.out_valid, bus.out_entry.id); end
        tick();
        bus.out_ready = 1'b0;
        #1;
        checks++; if (usage_o !== 3'd0) begin failures++; $display("FAIL gate_drain got %0d want 0", usage_o); end
    endtask

    task automatic test_wb_count();
        req_entry_t seq [3];
        seq[0] = mk(32'hA0B52553, 3, 1'b1, 1'b0);
        seq[1] = mk(32'h00A50553, 4, 1'b0, 1'b0);
        seq[2] = mk(32'hE0050553, 5, 1'b1, 1'b0);
        bus.out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bus.in_valid = 1'b1; bus.in_entry = seq[i];
            tick();
        end
        bus.in_valid = 1'b0;
        #1;
        checks++; if (wb_pending_o !== 3'd2 || usage_o !== 3'd3) begin failures++; $display("FAIL wb_fill got wb=%0d usage=%0d want 2/3", wb_pending_o, usage_o); end
        bus.out_ready = 1'b1;
        tick(); #1;
        checks++; if (wb_pending_o !== 3'd1 || bus.out_entry.id !== 4'd4) begin failures++; $display("FAIL wb_pop_feq got wb=%0d head=%0d want 1/4", wb_pending_o, bus.out_entry.id); end
        tick(); #1;
        checks++; if (wb_pending_o !== 3'd1 || usage_o !== 3'd1) begin failures++; $display("FAIL wb_pop_fadd got wb=%0d usage=%0d want 1/1", wb_pending_o, usage_o); end
        tick();
        bus.out_ready = 1'b0;
        #1;
        checks++; if (wb_pending_o !== 3'd0 || usage_o !== 3'd0) begin failures++; $display("FAIL wb_pop_fmv got wb=%0d usage=%0d want 0/0", wb_pending_o, usage_o); end
    endtask

    task automatic test_flush();
        bus.out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bus.in_valid = 1'b1; bus.in_entry = mk(32'hE0050553, 10 + i, 1'b1, 1'b0);
            tick();
        end
        #1;
        checks++; if (usage_o !== 3'd3 || wb_pending_o !== 3'd3) begin failures++; $display("FAIL flush_pre got usage=%0d wb=%0d want 3/3", usage_o, wb_pending_o); end
        flush_i = 1'b1; bus.in_entry = mk(32'h00A50553, 15, 1'b1, 1'b0);
        #1;
        checks++; if (bus.in_ready !== 1'b0) begin failures++; $display("FAIL flush_in_ready got %b want 0", bus.in_ready); end
        tick();
        flush_i = 1'b0; bus.in_valid = 1'b0;
        #1;
        checks++; if (usage_o !== 3'd0 || wb_pending_o !== 3'd0 || bus.out_valid !== 1'b0) begin failures++; $display("FAIL flush_post got usage=%0d wb=%0d v=%b want 0/0/0", usage_o, wb_pending_o, bus.out_valid); end
        bus.in_valid = 1'b1; bus.in_entry = mk(32'h00A50553, 9, 1'b0, 1'b0);
        tick();
        bus.in_valid = 1'b0;
        #1;
        checks++; if (bus.out_valid !== 1'b1 || bus.out_entry.id !== 4'd9 || usage_o !== 3'd1) begin failures++; $display("FAIL flush_repush got v=%b id=%0d usage=%0d want 1/9/1", bus.out_valid, bus.out_entry.id, usage_o); end
    endtask

    task automatic test_reset_mid();
        bus.in_valid = 1'b1; bus.in_entry = mk(32'h00A50553, 6, 1'b1, 1'b0);
        tick();
        bus.in_valid = 1'b0;
        #1;
        checks++; if (bus.out_valid !== 1'b1 || usage_o !== 3'd2) begin failures++; $display("FAIL mid_pre got v=%b usage=%0d want 1/2", bus.out_valid, usage_o); end
        rst_ni = 1'b0;
        #1;
        checks++; if (bus.out_valid !== 1'b0 || usage_o !== 3'd0 || wb_pending_o !== 3'd0 || bus.in_ready !== 1'b0) begin failures++; $display("FAIL mid_reset got v=%b usage=%0d wb=%0d rdy=%b want 0/0/0/0", bus.out_valid, usage_o, wb_pending_o, bus.in_ready); end
        tick();
        rst_ni = 1'b1;
        tick(); #1;
        checks++; if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin failures++; $display("FAIL mid_release got rdy=%b v=%b want 1/0", bus.in_ready, bus.out_valid); end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_latency();
        test_wrap();
        test_mem_gating();
        test_wb_count();
        test_flush();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
